// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit word registered through DEPTH stages with valid/ready handshake,
// bubble collapsing and flush. Define DFF_PIPE_OCC_EN to add the occ counter port.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] adv;

  // A stage advances when it is empty or everything downstream of it moves.
  always_comb begin : adv_chain
    logic carry;
    adv   = '0;
    carry = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      carry  = ~vld_q[i] | carry;
      adv[i] = carry;
    end
  end

  // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv[0]) begin
      vld_d[0] = in_valid & ~flush;
      if (in_valid & ~flush) data_d[0] = d;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
    // Flush drops every word but freezes the data so q keeps its last value.
    if (flush) begin
      vld_d  = '0;
      data_d = data_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  // NOTE: data registers are reset too, because q exposes stage DEPTH-1 directly.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = vld_q[DEPTH-1];
  assign q         = data_q[DEPTH-1];
  assign qbar      = ~data_q[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush)                  occ_d = '0;
    else if (accept & ~consume) occ_d = occ_q + OCC_W'(1);
    else if (consume & ~accept) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus randomized traffic
// compared against a word-position queue model of the pipeline.
module tb_dff_pipe;
  localparam int               WIDTH     = 8;
  localparam int               DEPTH     = 4;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

  logic             clk, clear, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] d, q, qbar;
`ifdef DFF_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: each held word with its stage position, oldest first.
  logic [WIDTH-1:0] mq_data[$];
  int               mq_pos[$];
  logic [WIDTH-1:0] m_q = RESET_VAL;

  // Pre-edge DUT samples and model expectations for the current cycle.
  logic             s_in_ready, s_out_valid, e_in_ready, e_out_valid;
  logic [WIDTH-1:0] s_q, s_qbar, e_q;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .clear(clear), .flush(flush), .d(d), .in_valid(in_valid),
    .in_ready(in_ready), .q(q), .qbar(qbar), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DFF_PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A word moves one stage forward if the slot ahead is free after the word ahead has moved.
  function automatic logic model_ready(input logic ordy, input logic fl);
    int lim = DEPTH;
    if (fl) return 1'b0;
    foreach (mq_pos[k]) begin
      if (k == 0 && mq_pos[0] == DEPTH - 1) lim = ordy ? DEPTH : DEPTH - 1;
      else lim = (mq_pos[k] + 1 < lim) ? mq_pos[k] + 1 : mq_pos[k];
    end
    return lim > 0;
  endfunction

  function automatic void model_step(input logic clr, input logic fl, input logic iv,
                                     input logic [WIDTH-1:0] din, input logic ordy);
    int  lim = DEPTH;
    bit  acc;
    if (clr) begin
      mq_data.delete(); mq_pos.delete(); m_q = RESET_VAL;
      return;
    end
    if (fl) begin
      mq_data.delete(); mq_pos.delete();
      return;
    end
    acc = iv && model_ready(ordy, 1'b0);
    foreach (mq_pos[k]) begin
      if (k == 0 && mq_pos[0] == DEPTH - 1) mq_pos[k] = ordy ? DEPTH : DEPTH - 1;
      else mq_pos[k] = (mq_pos[k] + 1 < lim) ? mq_pos[k] + 1 : mq_pos[k];
      lim = mq_pos[k];
    end
    if (mq_pos.size() > 0 && mq_pos[0] == DEPTH) begin
      void'(mq_pos.pop_front());
      void'(mq_data.pop_front());
    end
    if (acc) begin
      mq_data.push_back(din);
      mq_pos.push_back(0);
    end
    if (mq_pos.size() > 0 && mq_pos[0] == DEPTH - 1) m_q = mq_data[0];
  endfunction

  // Drive one cycle: inputs at edge+1, sample before the edge, advance the model on the edge.
  task automatic cycle(input logic clr, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] din, input logic ordy);
    clear = clr; flush = fl; in_valid = iv; d = din; out_ready = ordy;
    #2;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_q         = q;
    s_qbar      = qbar;
    e_in_ready  = model_ready(ordy, fl);
    e_out_valid = (mq_pos.size() > 0 && mq_pos[0] == DEPTH - 1);
    e_q         = m_q;
    @(posedge clk);
    model_step(clr, fl, iv, din, ordy);
    #1;
  endtask

`ifdef DFF_PIPE_OCC_EN
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (int'(occ) !== mq_pos.size()) begin
        errors++;
        $display("FAIL occ_invariant: got %0d expected %0d at %0t", occ, mq_pos.size(), $time);
      end
    end
  end
`endif

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'hE5, 1'b1);
    chk_en = 1'b1;
    clear = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
    checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h expected ff", qbar); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef DFF_PIPE_OCC_EN
    checks++; if (occ !== '0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
  endtask

  task automatic test_fill_backpressure();
    logic [WIDTH-1:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b1, vals[k], 1'b0);
      checks++;
      if (s_in_ready !== logic'(k < 4)) begin
        errors++; $display("FAIL fill_in_ready[%0d]: got %b expected %b", k, s_in_ready, k < 4);
      end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || q !== 8'h11) begin
      errors++; $display("FAIL full_head: got v=%b q=%h expected v=1 q=11", out_valid, q);
    end
`ifdef DFF_PIPE_OCC_EN
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d expected 4", occ); end
`endif
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, logic'(k == 0), 8'h55, 1'b1);
      checks++;
      if (s_out_valid !== 1'b1 || s_q !== vals[k]) begin
        errors++; $display("FAIL drain_q[%0d]: got v=%b q=%h expected v=1 q=%h", k, s_out_valid, s_q, vals[k]);
      end
      checks++;
      if (s_in_ready !== e_in_ready) begin
        errors++; $display("FAIL drain_in_ready[%0d]: got %b expected %b", k, s_in_ready, e_in_ready);
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    int n_out = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, 1'b0, logic'(c < 10), 8'hA0 + 8'(c), 1'b1);
      if (c < 10) begin
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", c, s_in_ready); end
      end
      if (s_out_valid === 1'b1) begin
        checks++;
        if (s_q !== 8'hA0 + 8'(n_out) || c !== DEPTH + n_out) begin
          errors++;
          $display("FAIL stream_out: got q=%h at cycle %0d expected q=%h at cycle %0d", s_q, c, 8'hA0 + 8'(n_out), DEPTH + n_out);
        end
        n_out++;
      end
    end
    checks++; if (n_out !== 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", n_out); end
  endtask

  task automatic test_bubble_collapse();
    cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bubble_accept_5a: got %b expected 1", s_in_ready); end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || q !== 8'h5A) begin
      errors++; $display("FAIL bubble_head: got v=%b q=%h expected v=1 q=5a", out_valid, q);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h6B, 1'b0);
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bubble_accept_6b: got %b expected 1", s_in_ready); end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready[%0d]: got %b expected 1", k, s_in_ready); end
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (s_out_valid !== 1'b1 || s_q !== 8'h5A) begin
      errors++; $display("FAIL bubble_out0: got v=%b q=%h expected v=1 q=5a", s_out_valid, s_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (s_out_valid !== 1'b1 || s_q !== 8'h6B) begin
      errors++; $display("FAIL bubble_out1: got v=%b q=%h expected v=1 q=6b", s_out_valid, s_q);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'h31 + 8'(k), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || q !== 8'h31) begin
      errors++; $display("FAIL flush_pre: got v=%b q=%h expected v=1 q=31", out_valid, q);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", s_in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (q !== 8'h31 || qbar !== 8'hCE) begin
      errors++; $display("FAIL flush_q_hold: got q=%h qbar=%h expected q=31 qbar=ce", q, qbar);
    end
`ifdef DFF_PIPE_OCC_EN
    checks++; if (occ !== '0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occ); end
`endif
    for (int k = 0; k < DEPTH + 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (s_out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak[%0d]: got v=%b q=%h expected v=0", k, s_out_valid, s_q);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n_out = 0;
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(c), 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'hCF, 1'b1);
    checks++; if (q !== RESET_VAL || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got v=%b q=%h expected v=0 q=%h", out_valid, q, RESET_VAL);
    end
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, logic'(c == 0), 8'hD0, 1'b1);
      if (s_out_valid === 1'b1) begin
        checks++;
        if (c !== DEPTH || s_q !== 8'hD0) begin
          errors++; $display("FAIL midreset_out: got q=%h at cycle %0d expected q=d0 at cycle %0d", s_q, c, DEPTH);
        end
        n_out++;
      end
    end
    checks++; if (n_out !== 1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", n_out); end
  endtask

  task automatic test_random();
    logic clr, fl, iv, ordy;
    logic [WIDTH-1:0] din;
    for (int c = 0; c < 600; c++) begin
      clr  = ($urandom_range(0, 63) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      din  = 8'($urandom);
      cycle(clr, fl, iv, din, ordy);
      checks++; if (s_in_ready !== e_in_ready) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, s_in_ready, e_in_ready);
      end
      checks++; if (s_out_valid !== e_out_valid) begin
        errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, s_out_valid, e_out_valid);
      end
      checks++; if (s_q !== e_q) begin
        errors++; $display("FAIL rand_q[%0d]: got %h expected %h", c, s_q, e_q);
      end
      checks++; if (s_qbar !== ~e_q) begin
        errors++; $display("FAIL rand_qbar[%0d]: got %h expected %h", c, s_qbar, ~e_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_backpressure();
    test_streaming();
    test_bubble_collapse();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit `dff_behavior` flop. Registers a WIDTH-bit word through DEPTH flop stages with a valid/ready handshake, bubble collapsing and a flush. It provides true and complement outputs (`q`, `qbar`) and is used wherever a retimed, back-pressurable data path is needed in place of discrete D flip-flops.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of register stages, which is also the capacity in words, ≥1.
- `RESET_VAL`, 0: WIDTH-bit value loaded into every data register on `clear`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous discard of all held words.
- `d`  in  WIDTH  input data.
- `in_valid`  in  1  `d` is valid this cycle.
- `in_ready`  out  1  the pipe accepts `d` this cycle.
- `q`  out  WIDTH  output data, equal to data register DEPTH-1.
- `qbar`  out  WIDTH  bitwise `~q` at all times.
- `out_valid`  out  1  `q` holds a valid word.
- `out_ready`  in  1  the consumer takes `q` this cycle.
- `occ`  out  $clog2(DEPTH+1)  number of valid stages; present only with `DFF_PIPE_OCC_EN`.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): `data[i]` (WIDTH bits) and `vld[i]` (1 bit).
- Advance chain (combinational):
  - `adv[DEPTH] = out_ready`.
  - `adv[i] = !vld[i] | adv[i+1]`.
  - `in_ready = adv[0] & !flush`.
- On each edge where `adv[i]` is high:
  - `vld[i] <=` source valid. The source is `in_valid & !flush` for stage 0, and `vld[i-1]` otherwise.
  - `data[i] <=` source data, but only when the source is valid. Otherwise `data[i]` holds its value.
- Stages with `adv[i]` low hold both `vld` and `data`.
- Bubble collapse: an empty stage always advances, so a word moves forward into gaps even while `out_ready` is 0.
- Handshakes:
  - Input accepted when `in_valid & in_ready`.
  - Output consumed when `out_valid & out_ready`.
  - `d` is sampled only on acceptance.
  - Once `out_valid` is asserted, `q` holds steady until it is consumed.
- Ordering: strict FIFO. No word is dropped or duplicated except by `flush` or `clear`.
- Reset (`clear` = 1):
  - All `vld` go to 0 and all `data` go to `RESET_VAL`.
  - Outputs after the edge: `out_valid`=0, `q`=`RESET_VAL`, `qbar`=`~RESET_VAL`, `in_ready`=1, `occ`=0.
  - `clear` overrides `flush` and the handshakes in the same cycle.
  - A `clear` mid-stream discards all words.
- Flush (`flush` = 1):
  - All `vld` go to 0 on the next edge. Data registers are unchanged, so `q` keeps its last value while `out_valid` goes to 0.
  - `in_ready` is 0 during the flush cycle.
  - A simultaneous `out_ready` handshake still counts as consumed in that cycle.

## Timing
- Latency: a word accepted on edge N into an empty pipe gives `out_valid`=1 after edge N+DEPTH-1. That is DEPTH cycles from the acceptance cycle to the first visible cycle.
- Throughput: 1 word/cycle with `out_ready` held at 1.
- `in_ready` depends combinationally on `out_ready` through the advance chain. This is intentional, since full-rate streaming needs it.
- Full (all DEPTH `vld`=1) with `out_ready`=0: `in_ready`=0.
- Full with `out_ready`=1: accept and consume happen in the same cycle and `occ` is unchanged.
- Empty: `out_valid`=0. `out_ready` is ignored.

## Configuration
- `DFF_PIPE_OCC_EN` defined:
  - Port `occ` and an occupancy counter are present.
  - The counter does +1 on an accept, -1 on a consume, no change on both, and goes to 0 on `flush` or `clear`.
  - The counter must always equal the popcount of `vld`; the bench asserts this every cycle.
- `DFF_PIPE_OCC_EN` undefined: no `occ` port and no counter. All other behaviour is identical.

## Test plan
- Reset: drive `clear`=1 for 2 cycles with WIDTH=8, RESET_VAL=8'h00 -> `q`=8'h00, `qbar`=8'hFF, `out_valid`=0, `in_ready`=1, `occ`=0.
- Fill/backpressure: `out_ready`=0, offer 0x11,0x22,0x33,0x44,0x55 back-to-back -> first four accepted, `in_ready`=0 from then on, `occ`=4. Then `out_ready`=1 -> `q` sequence 0x11,0x22,0x33,0x44 on consecutive cycles, then 0x55.
- Streaming: `out_ready`=1, 10 consecutive words starting 0xA0 -> `out_valid` first high DEPTH=4 cycles after the first accept, then one word per cycle in order, no gaps.
- Bubble collapse: one word 0x5A, then 3 idle cycles, `out_ready`=0 -> 0x5A reaches stage 3. A second word 0x6B fills stage 2 behind it. `in_ready` stays 1.
- Flush: pipe holding 3 words, assert `flush` together with `in_valid` carrying 0x77 -> after the edge, `out_valid`=0, `occ`=0, 0x77 not accepted, `q` unchanged.
- Mid-operation reset: while streaming, assert `clear` for 1 cycle -> all words lost, `q`=RESET_VAL, and the next accepted word emerges with the normal latency of 4.
